// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset defaults and state encoding for the fetch unit
package fetch_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT  = 16'h0000;
    localparam logic [PC_W-1:0] TRAP_PC_DEFAULT   = 16'h0010;
    localparam logic [PC_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_mux.sv
// rtl/fetch_pc_mux.sv - next-PC priority select: mispredict > trap > jump > increment > hold
module fetch_pc_mux
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] TRAP_PC = TRAP_PC_DEFAULT
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic            i_mispredict,
    input  logic [PC_W-1:0] i_ex_target,
    input  logic            i_trap_req,
    input  logic            i_jump,
    input  logic            i_j_sel,
    input  logic [PC_W-1:0] i_new_pc,
    input  logic [PC_W-1:0] i_jreg_target,
    output logic [PC_W-1:0] o_next_pc,
    output logic            o_issue,
    output logic            o_squash,
    output logic            o_trap
);

    logic w_accept;
    logic w_trap;
    logic w_jump;

    // Decoder-side redirects only act on an instruction decode is actually consuming.
    assign w_accept = i_valid & ~i_stall;
    assign w_trap   = i_trap_req & w_accept & ~i_mispredict;
    assign w_jump   = i_jump & w_accept & ~i_mispredict & ~w_trap;

    always_comb begin
        o_next_pc = i_pc;
        if (i_mispredict) begin
            o_next_pc = i_ex_target;
        end else if (w_trap) begin
            o_next_pc = TRAP_PC;
        end else if (w_jump) begin
            o_next_pc = i_j_sel ? i_jreg_target : i_new_pc;
        end else if (!i_stall) begin
            o_next_pc = i_pc + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_squash = i_mispredict | w_trap | w_jump;
    assign o_issue  = ~i_stall & ~o_squash;
    assign o_trap   = w_trap;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch front end: PC, imem read, decode-stall hold, redirects
// Optional privilege-trap redirect enabled by defining FETCH_TRAP_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] TRAP_PC   = TRAP_PC_DEFAULT,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            id_jump,
    input  logic            id_j_sel,
    input  logic [PC_W-1:0] id_new_pc,
    input  logic [PC_W-1:0] jreg_target,
    input  logic            ex_mispredict,
    input  logic [PC_W-1:0] ex_target,
    input  logic            bad_instr,
    output logic            imem_re,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] i_addr,
    output logic            instr_valid,
    output logic            trap_taken,
    output logic [PC_W-1:0] trap_epc
);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_ia_q;
    logic [PC_W-1:0] r_hold_instr;
    logic [PC_W-1:0] r_hold_addr;
    logic            r_pend;

    logic            w_hold;
    logic            w_valid;
    logic            w_trap_req;
    logic [PC_W-1:0] w_next_pc;
    logic            w_issue;
    logic            w_squash;
    logic            w_trap;

    assign w_hold      = (r_state == ST_HOLD);
    assign w_valid     = w_hold | r_pend;
    assign instr_valid = w_valid;
    assign instr       = w_hold ? r_hold_instr : (r_pend ? imem_rdata : NOP_INSTR);
    assign i_addr      = w_hold ? r_hold_addr : r_ia_q;
    assign imem_addr   = r_pc;
    // Gated by reset so no read strobe escapes while the PC is being forced.
    assign imem_re     = w_issue & rst_n;
    assign trap_taken  = w_trap;

`ifdef FETCH_TRAP_EN
    logic [PC_W-1:0] r_trap_epc;

    assign w_trap_req = bad_instr;
    assign trap_epc   = r_trap_epc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_epc <= '0;
        end else if (w_trap) begin
            r_trap_epc <= i_addr;
        end
    end
`else
    logic w_unused_bad_instr;

    assign w_unused_bad_instr = bad_instr;
    assign w_trap_req         = 1'b0;
    assign trap_epc           = '0;
`endif

    fetch_pc_mux #(
        .TRAP_PC (TRAP_PC)
    ) u_pc_mux (
        .i_pc          (r_pc),
        .i_valid       (w_valid),
        .i_stall       (stall),
        .i_mispredict  (ex_mispredict),
        .i_ex_target   (ex_target),
        .i_trap_req    (w_trap_req),
        .i_jump        (id_jump),
        .i_j_sel       (id_j_sel),
        .i_new_pc      (id_new_pc),
        .i_jreg_target (jreg_target),
        .o_next_pc     (w_next_pc),
        .o_issue       (w_issue),
        .o_squash      (w_squash),
        .o_trap        (w_trap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pend       <= 1'b0;
            r_ia_q       <= '0;
            r_hold_instr <= NOP_INSTR;
            r_hold_addr  <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_issue) begin
                r_ia_q  <= r_pc;
                r_pend  <= 1'b1;
                r_state <= ST_RUN;
            end else begin
                r_pend <= 1'b0;
                if (w_squash) begin
                    r_state <= ST_RUN;
                end else if (!w_hold && r_pend) begin
                    // Capture the live read data before the memory output moves on.
                    r_hold_instr <= imem_rdata;
                    r_hold_addr  <= r_ia_q;
                    r_state      <= ST_HOLD;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed self-checking bench for instr_fetch
module tb_instr_fetch;

    localparam logic [15:0] TRAP_PC = 16'h0010;
    localparam logic [15:0] NOP     = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_jump;
    logic        id_j_sel;
    logic [15:0] id_new_pc;
    logic [15:0] jreg_target;
    logic        ex_mispredict;
    logic [15:0] ex_target;
    logic        bad_instr;
    logic        imem_re;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic [15:0] i_addr;
    logic        instr_valid;
    logic        trap_taken;
    logic [15:0] trap_epc;

    // Reference view: what decode sees, and where fetch will read next.
    logic        m_valid;
    logic [15:0] m_addr;
    logic [15:0] m_pc;
    logic [15:0] m_epc;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .id_jump       (id_jump),
        .id_j_sel      (id_j_sel),
        .id_new_pc     (id_new_pc),
        .jreg_target   (jreg_target),
        .ex_mispredict (ex_mispredict),
        .ex_target     (ex_target),
        .bad_instr     (bad_instr),
        .imem_re       (imem_re),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .i_addr        (i_addr),
        .instr_valid   (instr_valid),
        .trap_taken    (trap_taken),
        .trap_epc      (trap_epc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_re) imem_rdata <= 16'h1000 + imem_addr;
    end

    function automatic logic exp_trap();
`ifdef FETCH_TRAP_EN
        return bad_instr && m_valid && !stall && !ex_mispredict;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_jump();
        return id_jump && m_valid && !stall && !ex_mispredict && !exp_trap();
    endfunction

    function automatic logic [66:0] exp_vec();
        logic        re;
        logic [15:0] ins;
        re  = !stall && !ex_mispredict && !exp_trap() && !exp_jump();
        ins = 16'h1000 + m_addr;
        return {m_valid, m_valid ? ins : NOP, m_valid ? m_addr : 16'h0000,
                re, re ? m_pc : 16'h0000, exp_trap(), m_epc};
    endfunction

    function automatic logic [66:0] obs_vec();
        return {instr_valid, instr, instr_valid ? i_addr : 16'h0000,
                imem_re, imem_re ? imem_addr : 16'h0000, trap_taken, trap_epc};
    endfunction

    task automatic model_step();
        if (ex_mispredict) begin
            m_valid = 1'b0;
            m_pc    = ex_target;
        end else if (exp_trap()) begin
            m_epc   = m_addr;
            m_valid = 1'b0;
            m_pc    = TRAP_PC;
        end else if (exp_jump()) begin
            m_valid = 1'b0;
            m_pc    = id_j_sel ? jreg_target : id_new_pc;
        end else if (!stall) begin
            m_valid = 1'b1;
            m_addr  = m_pc;
            m_pc    = m_pc + 16'd1;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = 16'h0000;
        m_pc    = 16'h0000;
        m_epc   = 16'h0000;
    endtask

    task automatic idle();
        stall         = 1'b0;
        id_jump       = 1'b0;
        id_j_sel      = 1'b0;
        id_new_pc     = 16'h0000;
        jreg_target   = 16'h0000;
        ex_mispredict = 1'b0;
        ex_target     = 16'h0000;
        bad_instr     = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({instr_valid, instr, i_addr, imem_re, trap_taken, trap_epc} !==
            {1'b0, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset got v=%b instr=%h ia=%h re=%b tt=%b epc=%h exp all zero",
                     instr_valid, instr, i_addr, imem_re, trap_taken, trap_epc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run_stall();
        int sc = 0;
        for (int c = 0; c < 16; c++) begin
            idle();
            stall = m_valid && m_addr == 16'h0005 && sc < 3;
            if (stall) sc++;
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL run_stall cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        bit done = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'h0006;
            end else if (m_valid && m_addr == 16'h0008 && !done) begin
                id_jump   = 1'b1;
                id_new_pc = 16'h0040;
                done      = 1;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL jump cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_jreg();
        int ph = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'h0040;
            end else if (m_valid && m_addr == 16'h0042 && ph < 2) begin
                id_jump     = 1'b1;
                id_j_sel    = 1'b1;
                id_new_pc   = 16'h0777;
                jreg_target = 16'h0123;
                stall       = (ph == 0);
                ph++;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL jreg cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_mispredict_hold();
        int ph = 0;
        for (int c = 0; c < 12; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'h0060;
            end else if (m_valid && m_addr == 16'h0062 && ph < 3) begin
                stall = 1'b1;
                if (ph == 2) begin
                    ex_mispredict = 1'b1;
                    ex_target     = 16'h0200;
                    id_jump       = 1'b1;
                    id_new_pc     = 16'h0300;
                end
                ph++;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL mispredict_hold cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        bit s30 = 0;
        bit t31 = 0;
        bit m12 = 0;
        for (int c = 0; c < 16; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'h002F;
            end else if (m_valid && m_addr == 16'h0030 && !s30) begin
                stall     = 1'b1;
                bad_instr = 1'b1;
                s30       = 1;
            end else if (m_valid && m_addr == 16'h0031 && !t31) begin
                bad_instr = 1'b1;
                id_jump   = 1'b1;
                id_new_pc = 16'h0500;
                t31       = 1;
            end else if (m_valid && m_addr == 16'h0012 && !m12) begin
                bad_instr     = 1'b1;
                ex_mispredict = 1'b1;
                ex_target     = 16'h0031;
                m12           = 1;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL trap cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'hFFFD;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stall         = ($urandom_range(0, 3) == 0);
            id_jump       = ($urandom_range(0, 7) == 0);
            id_j_sel      = 1'($urandom);
            id_new_pc     = 16'($urandom);
            jreg_target   = 16'($urandom);
            ex_mispredict = ($urandom_range(0, 15) == 0);
            ex_target     = 16'($urandom);
            bad_instr     = ($urandom_range(0, 9) == 0);
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_hold();
        int sc = 0;
        for (int c = 0; c < 8 && sc < 2; c++) begin
            idle();
            if (c == 0) begin
                ex_mispredict = 1'b1;
                ex_target     = 16'h0070;
            end else if (m_valid) begin
                stall = 1'b1;
                sc++;
            end
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
        stall = 1'b0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({instr_valid, instr, i_addr, imem_re, trap_taken, trap_epc} !==
            {1'b0, NOP, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_mid_hold got v=%b instr=%h ia=%h re=%b tt=%b epc=%h exp all zero",
                     instr_valid, instr, i_addr, imem_re, trap_taken, trap_epc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            idle();
            #1;
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            model_step();
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_free_run_stall();
        test_jump();
        test_jreg();
        test_mispredict_hold();
        test_trap();
        test_wrap();
        test_random();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
